// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction SRAM port, redirect input and the
// valid/ready handshake toward decode.
interface if_stage_if;
    logic        io_inst_en;
    logic        io_inst_we;
    logic [31:0] io_inst_addr;
    logic [31:0] io_inst_wdata;
    logic [31:0] io_inst_rdata;
    logic        io_br_taken;
    logic [31:0] io_br_target;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_pc;
    logic [31:0] io_out_inst;

    // Fetch stage side
    modport master (
        output io_inst_en, io_inst_we, io_inst_addr, io_inst_wdata,
        input  io_inst_rdata,
        input  io_br_taken, io_br_target,
        output io_out_valid,
        input  io_out_ready,
        output io_out_pc, io_out_inst
    );

    // Environment side: SRAM, redirect source and decode
    modport slave (
        input  io_inst_en, io_inst_we, io_inst_addr, io_inst_wdata,
        output io_inst_rdata,
        output io_br_taken, io_br_target,
        input  io_out_valid,
        output io_out_ready,
        input  io_out_pc, io_out_inst
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage. Issues sequential SRAM reads, offers each returned
// word to decode one cycle later, parks it in a one-entry buffer when decode
// stalls, and restarts at a redirect target with top priority.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic       clock,
    input  logic       reset,
    if_stage_if.master bus
);
    logic        run;
    logic        pend;
    logic        buf_valid;
    logic [31:0] seq_pc;
    logic [31:0] req_pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;

    logic        out_valid;
    logic        fire;
    logic        inst_en;
    logic        capture;
    logic [31:0] inst_addr;

    // Offer selection, handshake and request generation
    always_comb begin
        out_valid = (buf_valid | pend) & ~bus.io_br_taken;
        fire      = out_valid & bus.io_out_ready;
        // A new request only issues when the current offer (if any) leaves
        // this cycle, which is what keeps the single buffer entry sufficient.
        inst_en   = run & (bus.io_br_taken | ~out_valid | bus.io_out_ready);
        inst_addr = bus.io_br_taken ? bus.io_br_target : seq_pc;
        // The SRAM word is only valid this one cycle; park it if decode stalls.
        capture   = pend & ~buf_valid & out_valid & ~bus.io_out_ready;
    end

    // Drive the bundle outputs; the buffer holds the older offer when valid
    always_comb begin
        bus.io_inst_en    = inst_en;
        bus.io_inst_we    = 1'b0;
        bus.io_inst_addr  = inst_addr;
        bus.io_inst_wdata = 32'd0;
        bus.io_out_valid  = out_valid;
        if (buf_valid) begin
            bus.io_out_pc   = buf_pc;
            bus.io_out_inst = buf_inst;
        end else begin
            bus.io_out_pc   = req_pc;
            bus.io_out_inst = bus.io_inst_rdata;
        end
    end

    // Fetch state: run flag, PCs, in-flight request and skid buffer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run       <= 1'b0;
            pend      <= 1'b0;
            buf_valid <= 1'b0;
            seq_pc    <= RESET_PC;
            req_pc    <= RESET_PC;
            buf_pc    <= 32'd0;
            buf_inst  <= 32'd0;
        end else begin
            run <= 1'b1;

            if (inst_en) begin
                req_pc <= inst_addr;
                seq_pc <= inst_addr + 32'd4;
                pend   <= 1'b1;
            end else begin
                pend   <= 1'b0;
            end

            // Redirect drops whatever is buffered; capture and buffer fire
            // are mutually exclusive because capture requires buf_valid=0.
            if (bus.io_br_taken) begin
                buf_valid <= 1'b0;
            end else if (capture) begin
                buf_valid <= 1'b1;
                buf_pc    <= req_pc;
                buf_inst  <= bus.io_inst_rdata;
            end else if (fire && buf_valid) begin
                buf_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle-by-cycle vector table plus a scoreboard of the
// instructions decode is expected to accept, and a mid-stream async reset.
module tb_if_stage;
    localparam logic [31:0] R = 32'h1C00_0000;

    typedef struct {
        logic        ready;
        logic        br;
        logic [31:0] tgt;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    logic clock;
    logic reset;
    if_stage_if bus();

    if_stage #(.RESET_PC(R)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vt[$];
    logic [63:0] sb[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model: word tagged with its address one cycle after a request,
    // garbage otherwise so a stale read cannot masquerade as held data.
    always @(posedge clock) begin
        if (bus.io_inst_en) bus.io_inst_rdata <= ~bus.io_inst_addr;
        else                bus.io_inst_rdata <= 32'hBAD0_BAD0;
    end

    function automatic vec_t mk(logic rdy, logic br, logic [31:0] tgt,
                                logic e_en, logic [31:0] e_addr,
                                logic e_valid, logic [31:0] e_pc);
        vec_t v;
        v.ready = rdy; v.br = br; v.tgt = tgt;
        v.e_en = e_en; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, sample mid-cycle, step to next falling edge.
    task automatic apply_row(input vec_t v, input int idx);
        logic [63:0] e;
        bus.io_out_ready = v.ready;
        bus.io_br_taken  = v.br;
        bus.io_br_target = v.tgt;
        if (v.ready && v.e_valid) sb.push_back({v.e_pc, ~v.e_pc});
        #2;
        chk($sformatf("en[%0d]", idx),    32'(bus.io_inst_en),    32'(v.e_en));
        chk($sformatf("addr[%0d]", idx),  bus.io_inst_addr,       v.e_addr);
        chk($sformatf("valid[%0d]", idx), 32'(bus.io_out_valid),  32'(v.e_valid));
        chk($sformatf("we[%0d]", idx),    32'(bus.io_inst_we) | bus.io_inst_wdata, 32'd0);
        if (v.e_valid) begin
            chk($sformatf("pc[%0d]", idx),   bus.io_out_pc,   v.e_pc);
            chk($sformatf("inst[%0d]", idx), bus.io_out_inst, ~v.e_pc);
        end
        if (bus.io_out_valid && bus.io_out_ready) begin
            if (sb.size() == 0) begin
                chk($sformatf("unexpected_fire[%0d]", idx), bus.io_out_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk($sformatf("sb_pc[%0d]", idx),   bus.io_out_pc,   e[63:32]);
                chk($sformatf("sb_inst[%0d]", idx), bus.io_out_inst, e[31:0]);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        bus.io_out_ready = 1'b1;
        bus.io_br_taken  = 1'b0;
        bus.io_br_target = 32'd0;

        // startup, sequential flow, 3-cycle stall, redirects, wrap, unaligned target
        vt.push_back(mk(1, 0, 0,             0, R,             0, 0));
        vt.push_back(mk(1, 0, 0,             1, R,             0, 0));
        vt.push_back(mk(1, 0, 0,             1, R + 32'h4,     1, R));
        vt.push_back(mk(0, 0, 0,             0, R + 32'h8,     1, R + 32'h4));
        vt.push_back(mk(0, 0, 0,             0, R + 32'h8,     1, R + 32'h4));
        vt.push_back(mk(0, 0, 0,             0, R + 32'h8,     1, R + 32'h4));
        vt.push_back(mk(1, 0, 0,             1, R + 32'h8,     1, R + 32'h4));
        vt.push_back(mk(1, 1, R + 32'h100,   1, R + 32'h100,   0, 0));
        vt.push_back(mk(1, 0, 0,             1, R + 32'h104,   1, R + 32'h100));
        vt.push_back(mk(1, 0, 0,             1, R + 32'h108,   1, R + 32'h104));
        vt.push_back(mk(0, 0, 0,             0, R + 32'h10C,   1, R + 32'h108));
        vt.push_back(mk(0, 0, 0,             0, R + 32'h10C,   1, R + 32'h108));
        vt.push_back(mk(0, 1, R + 32'h200,   1, R + 32'h200,   0, 0));
        vt.push_back(mk(1, 0, 0,             1, R + 32'h204,   1, R + 32'h200));
        vt.push_back(mk(1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0));
        vt.push_back(mk(1, 0, 0,             1, 32'h0000_0000, 1, 32'hFFFF_FFFC));
        vt.push_back(mk(1, 0, 0,             1, 32'h0000_0004, 1, 32'h0000_0000));
        vt.push_back(mk(1, 1, 32'h0000_1233, 1, 32'h0000_1233, 0, 0));
        vt.push_back(mk(1, 0, 0,             1, 32'h0000_1237, 1, 32'h0000_1233));
        vt.push_back(mk(0, 0, 0,             0, 32'h0000_123B, 1, 32'h0000_1237));
        vt.push_back(mk(0, 0, 0,             0, 32'h0000_123B, 1, 32'h0000_1237));

        // reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_en",    32'(bus.io_inst_en),   32'd0);
        chk("rst_valid", 32'(bus.io_out_valid), 32'd0);
        chk("rst_addr",  bus.io_inst_addr,      R);
        chk("rst_we",    32'(bus.io_inst_we),   32'd0);
        chk("rst_wdata", bus.io_inst_wdata,     32'd0);

        reset = 1'b0;
        for (int i = 0; i < vt.size(); i++) apply_row(vt[i], i);

        // async reset mid-stream with the buffer holding 0x1237
        bus.io_out_ready = 1'b0;
        bus.io_br_taken  = 1'b0;
        #2;
        chk("pre_rst_valid", 32'(bus.io_out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.io_out_valid), 32'd0);
        chk("async_rst_en",    32'(bus.io_inst_en),   32'd0);
        chk("async_rst_addr",  bus.io_inst_addr,      R);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) apply_row(vt[i], 100 + i);
        apply_row(mk(1, 0, 0, 1, R + 32'h8, 1, R + 32'h4), 103);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1C000000, first fetch address after reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 io_inst_en  output  1  instruction SRAM request enable.
REQ-005 io_inst_we  output  1  instruction SRAM write enable; constant 0.
REQ-006 io_inst_addr  output  32  instruction SRAM byte address.
REQ-007 io_inst_wdata  output  32  instruction SRAM write data; constant 0.
REQ-008 io_inst_rdata  input  32  SRAM read data, valid exactly one cycle after the cycle io_inst_en=1.
REQ-009 io_br_taken  input  1  redirect request from downstream, single-cycle pulse.
REQ-010 io_br_target  input  32  redirect address, valid when io_br_taken=1.
REQ-011 io_out_valid  output  1  instruction/PC pair offered to decode.
REQ-012 io_out_ready  input  1  decode accepts the offered pair.
REQ-013 io_out_pc  output  32  PC of offered instruction.
REQ-014 io_out_inst  output  32  offered instruction word.

Function
REQ-015 State registers: run (1), seq_pc (32), req_pc (32), pend (1), buf_valid (1), buf_pc (32), buf_inst (32).
REQ-016 run is 0 out of reset and becomes 1 on the first rising edge after reset deasserts; it is never cleared except by reset.
REQ-017 Output select: buf_valid=1 -> offer (buf_pc, buf_inst); else pend=1 -> offer (req_pc, io_inst_rdata); else no offer.
REQ-018 io_out_valid = (buf_valid | pend) & ~io_br_taken.
REQ-019 fire = io_out_valid & io_out_ready; a transfer occurs only on fire.
REQ-020 io_inst_en = run & (io_br_taken | ~io_out_valid | io_out_ready).
REQ-021 io_inst_addr = io_br_taken ? io_br_target : seq_pc.
REQ-022 On an edge with io_inst_en=1: req_pc <= io_inst_addr, seq_pc <= io_inst_addr + 4 (modulo 2^32, wraps 0xFFFFFFFC -> 0x00000000), pend <= 1.
REQ-023 On an edge with io_inst_en=0: pend <= 0; seq_pc and req_pc hold.
REQ-024 Capture: pend=1, buf_valid=0, io_out_valid=1, io_out_ready=0 -> buf_valid <= 1, buf_pc <= req_pc, buf_inst <= io_inst_rdata.
REQ-025 buf_valid clears on fire from the buffer; capture (REQ-024) and buffer fire never occur on the same edge.
REQ-026 Buffer depth is one entry; REQ-020 guarantees no new request issues while an unaccepted offer exists, so overflow is impossible.
REQ-027 Redirect priority: io_br_taken=1 overrides all; the offered instruction is dropped, buf_valid <= 0, any in-flight data discarded, and a request to io_br_target issues the same cycle.
REQ-028 io_br_taken while run=0 is ignored except that buf_valid stays 0; no request issues.
REQ-029 io_br_target is used unaligned as given; alignment is the responsibility of the producer.
REQ-030 Steady-state throughput with io_out_ready held 1: one instruction per cycle; fetch-to-offer latency 1 cycle.
REQ-031 io_out_pc/io_out_inst are don't-care when io_out_valid=0.

Reset
REQ-032 While reset is asserted: run=0, pend=0, buf_valid=0, seq_pc=RESET_PC, req_pc=RESET_PC, buf_pc=0, buf_inst=0; hence io_inst_en=0, io_out_valid=0, io_inst_addr=RESET_PC, io_inst_we=0, io_inst_wdata=0.
REQ-033 Reset asserted mid-operation clears all state immediately without waiting for a clock edge; pending or buffered instructions are lost.
REQ-034 After reset release: edge 1 sets run; cycle 2 issues RESET_PC; cycle 3 offers RESET_PC.

Verification
REQ-035 Reset release, io_out_ready=1, SRAM returns addr-tagged words -> offers PC 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles starting cycle 3.
REQ-036 io_out_ready=0 for 3 cycles while 0x1C000004 is offered -> offer holds PC 0x1C000004 with the identical inst, io_inst_en=0 throughout, no PC skipped or repeated after ready returns.
REQ-037 io_br_taken=1, io_br_target=0x1C000100 while 0x1C000008 is offered -> io_out_valid=0 that cycle, io_inst_addr=0x1C000100, next offer PC 0x1C000100 then 0x1C000104.
REQ-038 Redirect while the buffer is full and io_out_ready=0 -> buffered instruction never offered; next offer is the target PC.
REQ-039 io_br_target=0xFFFFFFFC, ready=1 -> offers 0xFFFFFFFC then 0x00000000.
REQ-040 Assert reset for one cycle mid-stream (asynchronously, between edges) -> io_out_valid and io_inst_en fall to 0 immediately; restart follows REQ-034 from 0x1C000000.
